// File: rtl/arbitro_memoria.sv
// Round-robin arbiter sharing one memory port among three masters:
//   0 = mask loader, 1 = pixel window reader, 2 = result writer.
// One transaction at a time: ESPERA -> ACCESO -> RESPUESTA -> ESPERA.
// Handshake: a master raises solicitud_i and keeps it (and escritura_i,
// direccion_i, datos_escritura_i) stable until it sees completado_i; the
// memory answers each strobe with a single-cycle lectura_completada.
// A wait-limit watchdog forces completion with error_tiempo if the memory
// never answers.
module arbitro_memoria #(
    parameter int ANCHO_DIR     = 10,
    parameter int ANCHO_DATOS   = 32,
    parameter int LIMITE_ESPERA = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   solicitud_0,
    input  logic                   solicitud_1,
    input  logic                   solicitud_2,
    input  logic                   escritura_0,
    input  logic                   escritura_1,
    input  logic                   escritura_2,
    input  logic [ANCHO_DIR-1:0]   direccion_0,
    input  logic [ANCHO_DIR-1:0]   direccion_1,
    input  logic [ANCHO_DIR-1:0]   direccion_2,
    input  logic [ANCHO_DATOS-1:0] datos_escritura_0,
    input  logic [ANCHO_DATOS-1:0] datos_escritura_1,
    input  logic [ANCHO_DATOS-1:0] datos_escritura_2,
    output logic                   concedido_0,
    output logic                   concedido_1,
    output logic                   concedido_2,
    output logic                   completado_0,
    output logic                   completado_1,
    output logic                   completado_2,
    output logic [ANCHO_DATOS-1:0] datos_lectura,
    output logic [ANCHO_DIR-1:0]   direccion_mem_fisica,
    output logic                   leer,
    output logic                   escribir,
    output logic [ANCHO_DATOS-1:0] datos_mem_escritura,
    input  logic [ANCHO_DATOS-1:0] datos_memoria,
    input  logic                   lectura_completada,
    output logic                   ocupado,
    output logic                   error_tiempo,
    output logic [1:0]             estado_dbg
);

    localparam logic [1:0] ESPERA    = 2'd0;
    localparam logic [1:0] ACCESO    = 2'd1;
    localparam logic [1:0] RESPUESTA = 2'd2;

    // Watchdog counter is 8 bits wide; the limit is taken modulo that width.
    localparam logic [7:0] LIMITE_C = 8'(LIMITE_ESPERA);

    logic [1:0]             estado_q, estado_d;
    logic [1:0]             ultimo_q, ultimo_d;
    logic [7:0]             cuenta_q, cuenta_d;
    logic [2:0]             concedido_q, concedido_d;
    logic [2:0]             completado_q, completado_d;
    logic [ANCHO_DIR-1:0]   dir_q, dir_d;
    logic [ANCHO_DATOS-1:0] wdata_q, wdata_d;
    logic [ANCHO_DATOS-1:0] rdata_q, rdata_d;
    logic                   leer_q, leer_d;
    logic                   escribir_q, escribir_d;
    logic                   error_q, error_d;

    logic [2:0]             sol;
    logic                   hay_ganador;
    logic [1:0]             ganador;
    logic                   esc_sel;
    logic [ANCHO_DIR-1:0]   dir_sel;
    logic [ANCHO_DATOS-1:0] wd_sel;

    assign sol = {solicitud_2, solicitud_1, solicitud_0};

    // Pick the first requester after the last one served (rotating priority).
    always_comb begin
        hay_ganador = |sol;
        ganador     = 2'd0;
        case (ultimo_q)
            2'd0: begin
                if (sol[1])      ganador = 2'd1;
                else if (sol[2]) ganador = 2'd2;
                else             ganador = 2'd0;
            end
            2'd1: begin
                if (sol[2])      ganador = 2'd2;
                else if (sol[0]) ganador = 2'd0;
                else             ganador = 2'd1;
            end
            default: begin
                if (sol[0])      ganador = 2'd0;
                else if (sol[1]) ganador = 2'd1;
                else             ganador = 2'd2;
            end
        endcase
    end

    // Route the winning master's command fields toward the port registers.
    always_comb begin
        esc_sel = escritura_0;
        dir_sel = direccion_0;
        wd_sel  = datos_escritura_0;
        case (ganador)
            2'd1: begin
                esc_sel = escritura_1;
                dir_sel = direccion_1;
                wd_sel  = datos_escritura_1;
            end
            2'd2: begin
                esc_sel = escritura_2;
                dir_sel = direccion_2;
                wd_sel  = datos_escritura_2;
            end
            default: begin
                esc_sel = escritura_0;
                dir_sel = direccion_0;
                wd_sel  = datos_escritura_0;
            end
        endcase
    end

    // Next-state logic for the arbitration FSM, strobes and watchdog.
    always_comb begin
        estado_d     = estado_q;
        ultimo_d     = ultimo_q;
        cuenta_d     = cuenta_q;
        concedido_d  = concedido_q;
        completado_d = completado_q;
        dir_d        = dir_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        leer_d       = leer_q;
        escribir_d   = escribir_q;
        error_d      = error_q;
        case (estado_q)
            ESPERA: begin
                if (hay_ganador) begin
                    dir_d       = dir_sel;
                    wdata_d     = wd_sel;
                    leer_d      = ~esc_sel;
                    escribir_d  = esc_sel;
                    concedido_d = 3'b001 << ganador;
                    ultimo_d    = ganador;
                    cuenta_d    = 8'd0;
                    estado_d    = ACCESO;
                end
            end
            ACCESO: begin
                cuenta_d = cuenta_q + 8'd1;
                // A memory answer wins over a simultaneous timeout.
                if (lectura_completada) begin
                    if (leer_q) begin
                        rdata_d = datos_memoria;
                    end
                    leer_d       = 1'b0;
                    escribir_d   = 1'b0;
                    completado_d = concedido_q;
                    estado_d     = RESPUESTA;
                end else if ((cuenta_q + 8'd1) == LIMITE_C) begin
                    leer_d       = 1'b0;
                    escribir_d   = 1'b0;
                    error_d      = 1'b1;
                    rdata_d      = '0;
                    completado_d = concedido_q;
                    estado_d     = RESPUESTA;
                end
            end
            RESPUESTA: begin
                concedido_d  = 3'b000;
                completado_d = 3'b000;
                estado_d     = ESPERA;
            end
            default: begin
                concedido_d  = 3'b000;
                completado_d = 3'b000;
                leer_d       = 1'b0;
                escribir_d   = 1'b0;
                estado_d     = ESPERA;
            end
        endcase
    end

    // State registers; reset drops strobes at once and re-arms requester 0 first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q     <= ESPERA;
            ultimo_q     <= 2'd2;
            cuenta_q     <= 8'd0;
            concedido_q  <= 3'b000;
            completado_q <= 3'b000;
            dir_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            leer_q       <= 1'b0;
            escribir_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            ultimo_q     <= ultimo_d;
            cuenta_q     <= cuenta_d;
            concedido_q  <= concedido_d;
            completado_q <= completado_d;
            dir_q        <= dir_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            leer_q       <= leer_d;
            escribir_q   <= escribir_d;
            error_q      <= error_d;
        end
    end

    assign concedido_0          = concedido_q[0];
    assign concedido_1          = concedido_q[1];
    assign concedido_2          = concedido_q[2];
    assign completado_0         = completado_q[0];
    assign completado_1         = completado_q[1];
    assign completado_2         = completado_q[2];
    assign datos_lectura        = rdata_q;
    assign direccion_mem_fisica = dir_q;
    assign leer                 = leer_q;
    assign escribir             = escribir_q;
    assign datos_mem_escritura  = wdata_q;
    assign ocupado              = (estado_q == ACCESO) || (estado_q == RESPUESTA);
    assign error_tiempo         = error_q;
    assign estado_dbg           = estado_q;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria with a small memory-side driver and a
// scoreboard of expected datos_lectura values.
module tb_arbitro_memoria;

    localparam int AD = 10;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    sol, esc;
    logic [AD-1:0] dir [3];
    logic [AW-1:0] wd  [3];
    logic [AW-1:0] datos_memoria;
    logic          lectura_completada;

    logic          concedido_0, concedido_1, concedido_2;
    logic          completado_0, completado_1, completado_2;
    logic [AW-1:0] datos_lectura, datos_mem_escritura;
    logic [AD-1:0] direccion_mem_fisica;
    logic          leer, escribir, ocupado, error_tiempo;
    logic [1:0]    estado_dbg;
    logic [2:0]    conc, comp;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] ultimo_dato;

    assign conc = {concedido_2, concedido_1, concedido_0};
    assign comp = {completado_2, completado_1, completado_0};

    always #5 clk = ~clk;

    arbitro_memoria #(
        .ANCHO_DIR(AD), .ANCHO_DATOS(AW), .LIMITE_ESPERA(8)
    ) dut (
        .clk(clk), .reset(reset),
        .solicitud_0(sol[0]), .solicitud_1(sol[1]), .solicitud_2(sol[2]),
        .escritura_0(esc[0]), .escritura_1(esc[1]), .escritura_2(esc[2]),
        .direccion_0(dir[0]), .direccion_1(dir[1]), .direccion_2(dir[2]),
        .datos_escritura_0(wd[0]), .datos_escritura_1(wd[1]), .datos_escritura_2(wd[2]),
        .concedido_0(concedido_0), .concedido_1(concedido_1), .concedido_2(concedido_2),
        .completado_0(completado_0), .completado_1(completado_1), .completado_2(completado_2),
        .datos_lectura(datos_lectura),
        .direccion_mem_fisica(direccion_mem_fisica),
        .leer(leer), .escribir(escribir),
        .datos_mem_escritura(datos_mem_escritura),
        .datos_memoria(datos_memoria),
        .lectura_completada(lectura_completada),
        .ocupado(ocupado), .error_tiempo(error_tiempo),
        .estado_dbg(estado_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_conc"}, 32'(conc), 32'd0);
        check({tag, "_comp"}, 32'(comp), 32'd0);
        check({tag, "_strobes"}, 32'({leer, escribir}), 32'd0);
        check({tag, "_ocupado"}, 32'(ocupado), 32'd0);
    endtask

    // Wait (bounded) for any grant, then require it to be the expected master.
    task automatic wait_grant(input int who);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (conc == 3'b000 && n < 20);
        check("grant", 32'(conc), 32'(1 << who));
    endtask

    // Completion cycle: pulse and grant on the same master, strobes low, data from scoreboard.
    task automatic expect_done(input int who);
        logic [AW-1:0] e;
        check("completado", 32'(comp), 32'(1 << who));
        check("concedido_resp", 32'(conc), 32'(1 << who));
        check("strobes_off", 32'({leer, escribir}), 32'd0);
        check("sb_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("datos_lectura", datos_lectura, e);
        end
    endtask

    // One full transaction: grant, hold for 'espera' cycles, memory answers.
    task automatic transaccion(input int who, input int espera, input logic [AW-1:0] rdata,
                               input logic [2:0] soltar);
        wait_grant(who);
        check("direccion", 32'(direccion_mem_fisica), 32'(dir[who]));
        check("leer", 32'(leer), 32'(esc[who] ? 1'b0 : 1'b1));
        check("escribir", 32'(escribir), 32'(esc[who]));
        check("ocupado", 32'(ocupado), 32'd1);
        if (esc[who]) check("datos_mem_escritura", datos_mem_escritura, wd[who]);
        for (int i = 0; i < espera; i++) begin
            tick();
            check("strobe_held", 32'({leer, escribir}), esc[who] ? 32'd1 : 32'd2);
            check("no_completado", 32'(comp), 32'd0);
        end
        datos_memoria      = rdata;
        lectura_completada = 1'b1;
        if (esc[who]) begin
            exp_q.push_back(ultimo_dato);
        end else begin
            exp_q.push_back(rdata);
            ultimo_dato = rdata;
        end
        tick();
        lectura_completada = 1'b0;
        datos_memoria      = $urandom;
        expect_done(who);
        sol = sol & ~soltar;
        tick();
        check_idle("post");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
        ultimo_dato = '0;
    endtask

    initial begin
        reset              = 1'b1;
        sol                = 3'b000;
        esc                = 3'b000;
        dir[0]             = '0;
        dir[1]             = '0;
        dir[2]             = '0;
        wd[0]              = '0;
        wd[1]              = '0;
        wd[2]              = '0;
        datos_memoria      = '0;
        lectura_completada = 1'b0;
        ultimo_dato        = '0;

        // Reset asserted off-edge: everything must clear without a clock.
        #23 reset = 1'b0;
        #1;
        check_idle("reset");
        check("reset_error", 32'(error_tiempo), 32'd0);
        check("reset_datos", datos_lectura, 32'd0);
        check("reset_dir", 32'(direccion_mem_fisica), 32'd0);
        check("reset_wdata", datos_mem_escritura, 32'd0);
        check("reset_estado", 32'(estado_dbg), 32'd0);
        #7 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_leer", 32'(leer), 32'd0);
        end

        // Single read from master 0.
        sol[0] = 1'b1;
        dir[0] = 10'd2;
        transaccion(0, 4, 32'hffff_ffff, 3'b001);

        // A stray memory done pulse while idle is ignored.
        lectura_completada = 1'b1;
        datos_memoria      = 32'h0bad_0bad;
        tick();
        lectura_completada = 1'b0;
        check_idle("stray");
        check("stray_datos", datos_lectura, 32'hffff_ffff);

        // Fairness: all three request continuously, grants rotate from master 0.
        do_reset();
        dir[0] = 10'd5;
        dir[1] = 10'd6;
        dir[2] = 10'd7;
        sol    = 3'b111;
        for (int k = 0; k < 6; k++) begin
            transaccion(k % 3, 3, $urandom, (k == 5) ? 3'b111 : 3'b000);
        end

        // Write from master 2: read data register must keep its last value.
        esc[2] = 1'b1;
        dir[2] = 10'h3ff;
        wd[2]  = 32'h1234_5678;
        sol[2] = 1'b1;
        transaccion(2, 2, 32'hdead_beef, 3'b100);
        esc[2] = 1'b0;

        // Timeout on master 1: memory never answers, limit is 8 ACCESO cycles.
        dir[1] = 10'h0aa;
        sol[1] = 1'b1;
        wait_grant(1);
        exp_q.push_back(32'd0);
        ultimo_dato = '0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_leer_held", 32'(leer), 32'd1);
            check("to_no_comp", 32'(comp), 32'd0);
            check("to_no_error", 32'(error_tiempo), 32'd0);
        end
        tick();
        expect_done(1);
        check("to_error", 32'(error_tiempo), 32'd1);
        sol[1] = 1'b0;
        tick();
        check_idle("to_post");
        check("to_error_sticky", 32'(error_tiempo), 32'd1);

        // Next request after a timeout is served normally.
        dir[0] = 10'h011;
        sol[0] = 1'b1;
        transaccion(0, 1, 32'h5a5a_a5a5, 3'b001);
        check("error_still", 32'(error_tiempo), 32'd1);

        // Reset two cycles into an access by master 1.
        dir[1] = 10'h055;
        sol[1] = 1'b1;
        wait_grant(1);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset_error", 32'(error_tiempo), 32'd0);
        sol[0] = 1'b1;
        dir[0] = 10'h022;
        ultimo_dato = '0;
        @(negedge clk);
        reset = 1'b1;
        transaccion(0, 2, 32'h0000_c0de, 3'b001);
        transaccion(1, 2, 32'h0000_beef, 3'b010);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench watchdog expired");
    end

endmodule
